// File: rtl/apb_rr_master.sv
// apb_rr_master
//   Two-requester APB master. Picks one command at a time round-robin,
//   runs the APB SETUP/ACCESS phases toward the slave, and returns read data
//   and error status to the requester that won. An ACCESS-phase timeout
//   aborts a transfer whose slave never raises PREADY.
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (bit i = requester i);
//                         req_ready is combinational, one-hot or zero
//   req_write/addr/wdata  per-requester command, packed by requester index
//   rsp_valid             one-cycle strobe on the granted requester's bit
//   rsp_rdata/rsp_err     shared response payload, held until the next one
//   busy                  high whenever the FSM is not IDLE
//   PSEL..PSLVERR         APB master interface
//
// state  | meaning
// IDLE   | waiting for a command; grant is combinational here
// SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS | APB access phase, waiting on PREADY or timeout
// RESP   | response strobe to the granted requester, bus released
module apb_rr_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    // Wide enough to hold TIMEOUT itself; one bit when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q;
    logic                last_grant_q;
    logic                gnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                busy_q;

    logic                gnt_vld_d;
    logic                gnt_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                tmo_hit_d;

    // Round-robin pick: on contention the requester that did not win last time.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_d     = 1'b0;
        if (state_q == S_IDLE) begin
            if (req_valid == 2'b11) begin
                gnt_vld_d = 1'b1;
                gnt_d     = ~last_grant_q;
            end else if (req_valid[0]) begin
                gnt_vld_d = 1'b1;
                gnt_d     = 1'b0;
            end else if (req_valid[1]) begin
                gnt_vld_d = 1'b1;
                gnt_d     = 1'b1;
            end
        end
    end

    assign req_ready = {gnt_vld_d & gnt_d, gnt_vld_d & ~gnt_d};

    // Saturating increment; the abort fires on the wait cycle that would
    // bring the count up to TIMEOUT.
    assign cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign tmo_hit_d = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        gnt_q        <= gnt_d;
                        last_grant_q <= gnt_d;
                        pwrite_q     <= req_write[gnt_d];
                        paddr_q      <= gnt_d ? req_addr[2*ADDR_W-1:ADDR_W]
                                              : req_addr[ADDR_W-1:0];
                        pwdata_q     <= gnt_d ? req_wdata[2*DATA_W-1:DATA_W]
                                              : req_wdata[DATA_W-1:0];
                        psel_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A ready slave wins over a timeout landing in the same cycle.
                    if (PREADY) begin
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else if (tmo_hit_d) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RESP: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Testbench for apb_rr_master: directed scenarios plus randomized traffic,
// responses checked through an expected-response queue.
module tb_apb_rr_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic            PSEL;
    logic            PENABLE;
    logic            PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;
    logic            PSLVERR;

    apb_rr_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          g;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          last_grant = 1;
    int          sl_waits = 0;
    logic        sl_err = 1'b0;
    logic [31:0] sl_rdata = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    // Slave: PREADY low for sl_waits ACCESS cycles, then completes.
    // Outside the completing cycle the bus inputs carry random junk.
    int acc_n  = 0;
    bit in_acc = 1'b0;
    initial begin
        PREADY  = 1'b0;
        PRDATA  = '0;
        PSLVERR = 1'b0;
    end
    always begin
        @(posedge PCLK);
        #1;
        if (PSEL && PENABLE) begin
            acc_n  = in_acc ? acc_n + 1 : 0;
            in_acc = 1'b1;
            if (acc_n >= sl_waits) begin
                PREADY  = 1'b1;
                PRDATA  = sl_rdata;
                PSLVERR = sl_err;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end else begin
            in_acc  = 1'b0;
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
        end
    end

    // Response monitor: every strobe must match the oldest expectation.
    always @(negedge PCLK) begin : mon
        rsp_t e;
        if (!PRESET && rsp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b, expected no response (t=%0t)",
                         rsp_valid, $time);
            end else begin
                e = exp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(oh(e.g)));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err",   64'(rsp_err),   64'(e.err));
            end
        end
    end

    // One command through the bus; expected grant, timing and response are
    // derived from the arbitration rule and the programmed slave behaviour.
    task automatic txn(input logic [1:0] mask, input logic [1:0] wr,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input int waits, input logic serr, input logic [31:0] sdata);
        int          g;
        int          alen;
        bit          tmo;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        ew;
        rsp_t        e;
        g    = (mask == 2'b11) ? (1 - last_grant) : (mask[0] ? 0 : 1);
        ea   = (g == 1) ? a1 : a0;
        ed   = (g == 1) ? d1 : d0;
        ew   = wr[g];
        tmo  = (waits >= TMO);
        alen = tmo ? TMO : waits + 1;
        @(posedge PCLK);
        #1;
        req_valid = mask;
        req_write = wr;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        sl_waits  = waits;
        sl_err    = serr;
        sl_rdata  = sdata;
        e.g       = g;
        e.rdata   = (ew || tmo) ? 32'h0 : sdata;
        e.err     = tmo ? 1'b1 : serr;
        exp_q.push_back(e);
        last_grant = g;
        @(negedge PCLK);
        check("accept_ready", 64'(req_ready), 64'(oh(g)));
        check("accept_busy",  64'(busy), 64'd0);
        check("accept_psel",  64'(PSEL), 64'd0);
        @(negedge PCLK);
        check("setup_psel",    64'(PSEL), 64'd1);
        check("setup_penable", 64'(PENABLE), 64'd0);
        check("setup_paddr",   64'(PADDR), 64'(ea));
        check("setup_pwrite",  64'(PWRITE), 64'(ew));
        check("setup_pwdata",  64'(PWDATA), 64'(ed));
        check("setup_ready",   64'(req_ready), 64'd0);
        check("setup_busy",    64'(busy), 64'd1);
        repeat (alen) begin
            @(negedge PCLK);
            check("access_psel",    64'(PSEL), 64'd1);
            check("access_penable", 64'(PENABLE), 64'd1);
            check("access_paddr",   64'(PADDR), 64'(ea));
            check("access_pwrite",  64'(PWRITE), 64'(ew));
            check("access_pwdata",  64'(PWDATA), 64'(ed));
            check("access_ready",   64'(req_ready), 64'd0);
            check("access_rsp",     64'(rsp_valid), 64'd0);
        end
        @(negedge PCLK);
        check("resp_psel",    64'(PSEL), 64'd0);
        check("resp_penable", 64'(PENABLE), 64'd0);
        check("resp_strobe",  64'(rsp_valid), 64'(oh(g)));
        check("resp_busy",    64'(busy), 64'd1);
        check("resp_paddr",   64'(PADDR), 64'(ea));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
            req_valid = 2'b00;
            @(negedge PCLK);
            check("idle_ready", 64'(req_ready), 64'd0);
            check("idle_busy",  64'(busy), 64'd0);
            check("idle_psel",  64'(PSEL), 64'd0);
            check("idle_rsp",   64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  m;
        logic [1:0]  w;
        logic [31:0] a0, a1;
        int          wt;
        PRESET    = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge PCLK);
        check("rst_psel",      64'(PSEL), 64'd0);
        check("rst_penable",   64'(PENABLE), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err",   64'(rsp_err), 64'd0);
        check("rst_paddr",     64'(PADDR), 64'd0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        idle(1);

        // single write from req0
        txn(2'b01, 2'b01, 32'h0, 32'h0, 32'hA5A50000, 32'h0, 0, 1'b0, 32'hDEADBEEF);
        idle(1);

        // req1 read with three wait states
        txn(2'b10, 2'b00, 32'h0, 32'h4, 32'h0, 32'h0, 3, 1'b0, 32'h12345678);

        // contention, both held valid: 0,1,0,1
        repeat (4)
            txn(2'b11, 2'b10, 32'h8, 32'h4, 32'h0, 32'h1, 0, 1'b0, 32'h0BADF00D);

        // slave error on write to RESULT
        txn(2'b01, 2'b01, 32'h8, 32'h0, 32'h55, 32'h0, 0, 1'b1, 32'h0);
        idle(1);

        // timeout, and PREADY arriving exactly on the limit cycle
        txn(2'b01, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0, 1000, 1'b0, 32'h11112222);
        txn(2'b10, 2'b00, 32'h0, 32'h8, 32'h0, 32'h0, TMO - 1, 1'b0, 32'hCAFEF00D);
        txn(2'b10, 2'b01, 32'h0, 32'h0, 32'h0, 32'h77, TMO, 1'b0, 32'h0);
        idle(1);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            m  = 2'($urandom_range(1, 3));
            w  = 2'($urandom_range(0, 3));
            a0 = 32'(4 * $urandom_range(0, 2));
            a1 = 32'(4 * $urandom_range(0, 2));
            wt = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 2);
            txn(m, w, a0, a1, $urandom, $urandom, wt, 1'($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(1);

        // reset in the middle of ACCESS: transfer dropped, arbitration restarts
        @(posedge PCLK);
        #1;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr  = {32'h0, 32'h4};
        sl_waits  = 1000;
        repeat (3) @(negedge PCLK);
        check("pre_rst_penable", 64'(PENABLE), 64'd1);
        #2;
        PRESET = 1'b1;
        #1;
        check("async_rst_psel",    64'(PSEL), 64'd0);
        check("async_rst_penable", 64'(PENABLE), 64'd0);
        check("async_rst_busy",    64'(busy), 64'd0);
        check("async_rst_rsp",     64'(rsp_valid), 64'd0);
        last_grant = 1;
        req_valid  = 2'b00;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        idle(2);
        txn(2'b11, 2'b00, 32'h8, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'h600DCAFE);
        txn(2'b11, 2'b11, 32'h8, 32'h4, 32'h9, 32'hA, 1, 1'b0, 32'h0);
        idle(2);

        check("rsp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Two-requester APB master: arbitrates command requests round-robin and sequences the standard APB SETUP/ACCESS phases toward the register slave (DATA 0x0, CONTROL 0x4, RESULT 0x8).
- Returns read data and error status to the winning requester.
- Adds an access-phase timeout so a slave that never asserts PREADY cannot hang the bus.
- Sits between test/firmware command sources and the APB slave.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS-phase cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester command valid; bit i = requester i.
- req_ready  out  2  per-requester accept; combinational, one-hot or zero.
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  2*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  packed write data.
- rsp_valid  out  2  one-cycle response strobe to the granted requester.
- rsp_rdata  out  DATA_W  response read data; shared by both requesters.
- rsp_err  out  1  response error (PSLVERR or timeout).
- busy  out  1  high whenever state is not IDLE.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (async, PRESET=1):
  - State IDLE; all outputs 0.
  - last_grant=1, so requester 0 wins first.
  - Timeout counter 0.
  - Any in-flight transfer is dropped with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs except req_ready are registered.
- IDLE:
  - If any req_valid, grant g: when both are valid, g = the requester not equal to last_grant; otherwise g = the valid one.
  - req_ready[g]=1 in this same cycle.
  - On the clock edge: capture write/addr/wdata of g, set last_grant=g, go to SETUP.
  - req_ready is 0 in every other state.
- SETUP:
  - PSEL=1, PENABLE=0.
  - PADDR/PWRITE/PWDATA = captured values.
  - Next state ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - PREADY=1: capture PRDATA (reads) or 0 (writes) into rsp_rdata; rsp_err=PSLVERR; go to RESP.
  - PREADY=0: timeout counter increments.
  - If TIMEOUT!=0 and counter reaches TIMEOUT: rsp_rdata=0, rsp_err=1, go to RESP.
  - PREADY=1 in the same cycle the limit is reached: the normal completion wins.
- RESP:
  - PSEL=0, PENABLE=0; rsp_valid[g]=1 for exactly one cycle.
  - Counter cleared; next state IDLE.
  - rsp_rdata/rsp_err hold until the next response.
- Latency:
  - Accept in cycle 0; PSEL=1 in cycle 1; PENABLE=1 in cycle 2.
  - With PREADY=1 in cycle 2, rsp_valid in cycle 3.
  - Each wait state adds 1 cycle.
  - Back-to-back commands: the next accept is possible in cycle 4, so throughput is 1 transfer per 4 cycles minimum.
- Responses carry no back-pressure; a requester must sample rsp_valid.
- PADDR/PWRITE/PWDATA retain their last values while in IDLE/RESP.
- A requester whose req_valid drops before it is granted is simply not granted; there is no error.
- Timeout counter is at least clog2(TIMEOUT+1) bits wide and never wraps.

Test Plan:
- Single write after reset: req0 write, addr 0x0, data 0xA5A50000; PREADY=1 in the first ACCESS cycle.
  - Required: req_ready=01 in cycle 0, PSEL=1 in cycle 1, PENABLE=1 in cycle 2, rsp_valid=01 in cycle 3, rsp_err=0, rsp_rdata=0.
- Contention: req0 read 0x8 and req1 write 0x4 data 0x1, both held valid.
  - Required: req0 is granted first, req1 second, then they alternate 0,1,0,1.
  - Each response strobe appears only on the granted requester's bit.
- Wait states: req1 read 0x4; slave holds PREADY=0 for 3 ACCESS cycles, then returns PRDATA=0x12345678.
  - Required: ACCESS lasts 4 cycles with PADDR=0x4 stable; rsp_valid=10; rsp_rdata=0x12345678; rsp_err=0.
- Slave error: write to 0x8 (RESULT); slave returns PREADY=1, PSLVERR=1.
  - Required: rsp_err=1; PSEL drops in the RESP cycle; busy=0 in the following cycle.
- Timeout with TIMEOUT=8: PREADY held 0 indefinitely.
  - Required: after 8 ACCESS cycles, rsp_valid pulses with rsp_err=1 and rsp_rdata=0; PSEL/PENABLE=0.
  - Variant: PREADY=1 on the 8th cycle gives a normal response with rsp_err=0.
- Reset mid-transfer: assert PRESET during ACCESS.
  - Required: PSEL/PENABLE/busy go to 0 immediately (asynchronously); no rsp_valid is issued.
  - After release, simultaneous requests are granted to req0 first.
